dma64_rd_burst_splitter: RTL

Read-side DMA stage that sits between a 64-bit memory-copier accelerator and the system DMA read interface. It accepts one read request (word index, length in 64-bit beats) from the accelerator and issues it downstream as a sequence of bursts of at most `MAX_BURST` beats. Returned beats are forwarded to the accelerator in order, with zero added latency. One `done` pulse is raised when the whole request has completed.

---
 rtl/dma64_rd_burst_splitter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dma64_rd_burst_splitter.sv
// Splits one accelerator read into DMA bursts of at most MAX_BURST beats. Burst requests are registered.
// Beats pass through combinationally (0 cycles) and only in XFER; accelerator backpressure stalls the DMA.
module dma64_rd_burst_splitter #(
   parameter int MAX_BURST = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        acc_rd_ctrl_valid,
   output logic        acc_rd_ctrl_ready,
   input  logic [31:0] acc_rd_ctrl_index,
   input  logic [31:0] acc_rd_ctrl_length,
   input  logic [2:0]  acc_rd_ctrl_size,
   input  logic [5:0]  acc_rd_ctrl_user,
   output logic        acc_rd_chnl_valid,
   input  logic        acc_rd_chnl_ready,
   output logic [63:0] acc_rd_chnl_data,
   output logic        dma_read_ctrl_valid,
   input  logic        dma_read_ctrl_ready,
   output logic [31:0] dma_read_ctrl_data_index,
   output logic [31:0] dma_read_ctrl_data_length,
   output logic [2:0]  dma_read_ctrl_data_size,
   output logic [5:0]  dma_read_ctrl_data_user,
   input  logic        dma_read_chnl_valid,
   output logic        dma_read_chnl_ready,
   input  logic [63:0] dma_read_chnl_data,
   output logic        busy,
   output logic        done
);

   localparam int              LP_BW  = $clog2(MAX_BURST) + 1;
   localparam logic [31:0]     LP_MAX = 32'(MAX_BURST);
   localparam logic [LP_BW-1:0] LP_ONE = LP_BW'(1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [31:0]      r_cur_index;
   logic [31:0]      r_remaining;
   logic [LP_BW-1:0] r_burst_left;
   logic [2:0]       r_size;
   logic [5:0]       r_user;
   logic             r_dma_vld;
   logic [31:0]      r_dma_idx;
   logic [31:0]      r_dma_len;

   logic [31:0]      w_cur_nxt;
   logic [31:0]      w_rem_nxt;
   logic             w_up_hs;
   logic             w_dma_hs;
   logic             w_beat;
   logic             w_xfer;

   assign w_xfer   = (r_state == S_XFER);
   assign w_up_hs  = acc_rd_ctrl_valid && acc_rd_ctrl_ready;
   assign w_dma_hs = (r_state == S_REQ) && r_dma_vld && dma_read_ctrl_ready;
   assign w_beat   = w_xfer && dma_read_chnl_valid && acc_rd_chnl_ready;

   always_comb begin
      w_next    = r_state;
      w_cur_nxt = r_cur_index;
      w_rem_nxt = r_remaining;
      case (r_state)
         S_IDLE: begin
            if (w_up_hs) begin
               w_cur_nxt = acc_rd_ctrl_index;
               w_rem_nxt = acc_rd_ctrl_length;
               w_next    = (acc_rd_ctrl_length == 32'd0) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (w_dma_hs) w_next = S_XFER;
         end
         S_XFER: begin
            if (w_beat) begin
               w_rem_nxt = r_remaining - 32'd1;
               if (r_burst_left == LP_ONE) begin
                  // index wraps modulo 2^32 by design
                  w_cur_nxt = r_cur_index + r_dma_len;
                  w_next    = (r_remaining == 32'd1) ? S_DONE : S_REQ;
               end
            end
         end
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      acc_rd_ctrl_ready   = (r_state == S_IDLE) && rst;
      acc_rd_chnl_valid   = 1'b0;
      dma_read_chnl_ready = 1'b0;
      acc_rd_chnl_data    = 64'd0;
      if (w_xfer) begin
         acc_rd_chnl_valid   = dma_read_chnl_valid;
         dma_read_chnl_ready = acc_rd_chnl_ready;
         acc_rd_chnl_data    = dma_read_chnl_data;
      end
      busy = (r_state != S_IDLE);
      done = (r_state == S_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_cur_index  <= 32'd0;
         r_remaining  <= 32'd0;
         r_burst_left <= '0;
         r_size       <= 3'd0;
         r_user       <= 6'd0;
         r_dma_vld    <= 1'b0;
         r_dma_idx    <= 32'd0;
         r_dma_len    <= 32'd0;
      end else begin
         r_state     <= w_next;
         r_cur_index <= w_cur_nxt;
         r_remaining <= w_rem_nxt;
         if (w_up_hs) begin
            r_size <= acc_rd_ctrl_size;
            r_user <= acc_rd_ctrl_user;
         end
         // request fields are computed once on REQ entry and held until accepted
         if ((w_next == S_REQ) && (r_state != S_REQ)) begin
            r_dma_vld <= 1'b1;
            r_dma_idx <= w_cur_nxt;
            r_dma_len <= (w_rem_nxt >= LP_MAX) ? LP_MAX : w_rem_nxt;
         end else if (w_dma_hs) begin
            r_dma_vld <= 1'b0;
         end
         if (w_dma_hs)
            r_burst_left <= r_dma_len[LP_BW-1:0];
         else if (w_beat)
            r_burst_left <= r_burst_left - LP_ONE;
      end
   end

   assign dma_read_ctrl_valid       = r_dma_vld;
   assign dma_read_ctrl_data_index  = r_dma_idx;
   assign dma_read_ctrl_data_length = r_dma_len;
   assign dma_read_ctrl_data_size   = r_size;
   assign dma_read_ctrl_data_user   = r_user;

endmodule
